// File: rtl/add_accum_unit.sv
// Registered add/sub/accumulate/clear unit with valid/ready handshakes on both sides.
// Holds one result; keeps a running accumulator and a wrapping count of accepted operations.
module add_accum_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic [ACC_WIDTH-1:0] acc_value,
    output logic [15:0]          op_count
);

    localparam int unsigned EW = ACC_WIDTH + 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [ACC_WIDTH-1:0] ALL_ONES = '1;

    logic [0:0]           r_state;
    logic [ACC_WIDTH-1:0] r_data;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [15:0]          r_count;

    logic [EW-1:0]        w_a_ext;
    logic [EW-1:0]        w_b_ext;
    logic [EW-1:0]        w_acc_ext;
    logic [EW-1:0]        w_sum;
    logic [EW-1:0]        w_diff;
    logic [EW-1:0]        w_acc_sum;
    logic [ACC_WIDTH-1:0] w_result;
    logic                 w_ovf;
    logic                 w_accept;

    assign w_a_ext   = {{(EW-WIDTH){1'b0}}, in_a};
    assign w_b_ext   = {{(EW-WIDTH){1'b0}}, in_b};
    assign w_acc_ext = {1'b0, r_acc};

    // The extra top bit carries out of the add/accumulate and is the borrow of the subtract.
    assign w_sum     = w_a_ext + w_b_ext;
    assign w_diff    = w_a_ext - w_b_ext;
    assign w_acc_sum = w_acc_ext + w_a_ext;

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        unique case (in_mode)
            MODE_ADD: begin
                w_result = w_sum[ACC_WIDTH-1:0];
                w_ovf    = w_sum[ACC_WIDTH];
            end
            MODE_SUB: begin
                w_result = w_diff[ACC_WIDTH-1:0];
                if (w_diff[ACC_WIDTH]) begin
                    w_ovf = 1'b1;
                    if (SATURATE) begin
                        w_result = '0;
                    end
                end
            end
            MODE_ACC: begin
                w_result = w_acc_sum[ACC_WIDTH-1:0];
                if (w_acc_sum[ACC_WIDTH]) begin
                    w_ovf = 1'b1;
                    if (SATURATE) begin
                        w_result = ALL_ONES;
                    end
                end
            end
            default: begin
                w_result = '0;
                w_ovf    = 1'b0;
            end
        endcase
    end

    // Ready depends only on the output side, never on in_valid.
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_data  <= w_result;
            r_ovf   <= w_ovf;
            r_count <= r_count + 16'd1;
            if (in_mode == MODE_ACC) begin
                r_acc <= w_result;
            end else if (in_mode == MODE_CLR) begin
                r_acc <= '0;
            end
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_ovf   = r_ovf;
    assign acc_value = r_acc;
    assign op_count  = r_count;

endmodule

// File: tb/tb_add_accum_unit.sv
// Bench for add_accum_unit: four parameter configurations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_add_accum_unit;

    localparam int NC = 4;  // cfg0: 16-bit sat, cfg1: 16-bit wrap, cfg2: 9-bit sat, cfg3: 9-bit wrap

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_a      = '0;
    logic [7:0] in_b      = '0;
    logic [1:0] in_mode   = '0;

    logic [NC-1:0] dut_ready;
    logic [NC-1:0] dut_valid;
    logic [NC-1:0] dut_ovf;
    logic [15:0]   dut_data [NC];
    logic [15:0]   dut_acc  [NC];
    logic [15:0]   dut_cnt  [NC];

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1'b1;

    int m_valid = 0;
    int m_cnt   = 0;
    int m_data [NC] = '{default: 0};
    int m_ovf  [NC] = '{default: 0};
    int m_acc  [NC] = '{default: 0};

    int e_sat  [3] = '{255, 510, 511};
    int e_wrap [3] = '{255, 510, 253};
    int e_ovf  [3] = '{0, 0, 1};

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_dut
            localparam int AW  = (gi < 2) ? 16 : 9;
            localparam bit SAT = ((gi % 2) == 0);
            logic [AW-1:0] w_data;
            logic [AW-1:0] w_acc;
            add_accum_unit #(
                .WIDTH    (8),
                .ACC_WIDTH(AW),
                .SATURATE (SAT)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid),
                .in_ready (dut_ready[gi]),
                .in_a     (in_a),
                .in_b     (in_b),
                .in_mode  (in_mode),
                .out_valid(dut_valid[gi]),
                .out_ready(out_ready),
                .out_data (w_data),
                .out_ovf  (dut_ovf[gi]),
                .acc_value(w_acc),
                .op_count (dut_cnt[gi])
            );
            assign dut_data[gi] = 16'(w_data);
            assign dut_acc[gi]  = 16'(w_acc);
        end
    endgenerate

    function automatic int cfg_aw(input int c);
        return (c < 2) ? 16 : 9;
    endfunction

    function automatic int cfg_sat(input int c);
        return ((c % 2) == 0) ? 1 : 0;
    endfunction

    // Arithmetic statement of the operation rules on plain integers.
    task automatic op_model(input int mode, input int a, input int b, input int acc,
                            input int aw, input int sat,
                            output int r, output int ovf, output int nacc);
        int lim;
        lim  = 1 << aw;
        ovf  = 0;
        nacc = acc;
        case (mode)
            0: r = a + b;
            1: begin
                r = a - b;
                if (r < 0) begin
                    ovf = 1;
                    r   = (sat != 0) ? 0 : r + lim;
                end
            end
            2: begin
                r = acc + a;
                if (r >= lim) begin
                    ovf = 1;
                    r   = (sat != 0) ? lim - 1 : r - lim;
                end
                nacc = r;
            end
            default: begin
                r    = 0;
                nacc = 0;
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        bit take;
        int r, o, na;
        if (rst) begin
            m_valid = 0;
            m_cnt   = 0;
            for (int c = 0; c < NC; c++) begin
                m_data[c] = 0;
                m_ovf[c]  = 0;
                m_acc[c]  = 0;
            end
        end else begin
            take = in_valid && ((m_valid == 0) || out_ready);
            if (take) begin
                for (int c = 0; c < NC; c++) begin
                    op_model(int'(in_mode), int'(in_a), int'(in_b), m_acc[c],
                             cfg_aw(c), cfg_sat(c), r, o, na);
                    m_data[c] = r;
                    m_ovf[c]  = o;
                    m_acc[c]  = na;
                end
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cfg%0d: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, c, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NC; c++) begin
                chk("in_ready", c, 32'(dut_ready[c]), 32'((m_valid == 0) || out_ready));
                chk("out_valid", c, 32'(dut_valid[c]), 32'(m_valid));
                if (m_valid != 0) begin
                    chk("out_data", c, 32'(dut_data[c]), m_data[c]);
                    chk("out_ovf", c, 32'(dut_ovf[c]), m_ovf[c]);
                end
                chk("acc_value", c, 32'(dut_acc[c]), m_acc[c]);
                chk("op_count", c, 32'(dut_cnt[c]), m_cnt);
            end
            if (verbose && dut_valid[0] && out_ready) begin
                $display("[TB] txn out_data=%0d ovf=%0b acc=%0d op_count=%0d",
                         dut_data[0], dut_ovf[0], dut_acc[0], dut_cnt[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        sample();
        chk("rst_out_valid", 0, 32'(dut_valid[0]), 0);
        chk("rst_out_data", 0, 32'(dut_data[0]), 0);
        chk("rst_out_ovf", 0, 32'(dut_ovf[0]), 0);
        chk("rst_acc", 0, 32'(dut_acc[0]), 0);
        chk("rst_count", 0, 32'(dut_cnt[0]), 0);
        rst = 1'b0;

        // Add and subtract
        op(2'b00, 8'd200, 8'd100);
        tick();
        in_valid = 1'b0;
        sample();
        chk("add_data", 0, 32'(dut_data[0]), 300);
        chk("add_ovf", 0, 32'(dut_ovf[0]), 0);

        op(2'b01, 8'd3, 8'd5);
        tick();
        in_valid = 1'b0;
        sample();
        chk("sub_sat_data", 0, 32'(dut_data[0]), 0);
        chk("sub_sat_ovf", 0, 32'(dut_ovf[0]), 1);
        chk("sub_wrap_data", 1, 32'(dut_data[1]), 32'h0000_FFFE);
        chk("sub_wrap_ovf", 1, 32'(dut_ovf[1]), 1);

        // Back-to-back accumulate overflow on the 9-bit configurations
        for (int k = 0; k < 3; k++) begin
            op(2'b10, 8'hFF, 8'h00);
            tick();
            sample();
            chk("accov_sat_data", 2, 32'(dut_data[2]), e_sat[k]);
            chk("accov_wrap_data", 3, 32'(dut_data[3]), e_wrap[k]);
            chk("accov_sat_ovf", 2, 32'(dut_ovf[2]), e_ovf[k]);
            chk("accov_wrap_ovf", 3, 32'(dut_ovf[3]), e_ovf[k]);
        end
        in_valid = 1'b0;
        chk("accov_acc16", 0, 32'(dut_acc[0]), 765);
        chk("accov_acc_sat", 2, 32'(dut_acc[2]), 511);
        chk("accov_acc_wrap", 3, 32'(dut_acc[3]), 253);

        // Clear between accumulates
        do_reset();
        op(2'b10, 8'd10, 8'd0);
        tick();
        sample();
        chk("clr_acc10", 0, 32'(dut_data[0]), 10);
        op(2'b11, 8'h55, 8'h66);
        tick();
        sample();
        chk("clr_data", 0, 32'(dut_data[0]), 0);
        op(2'b10, 8'd7, 8'd0);
        tick();
        in_valid = 1'b0;
        sample();
        chk("clr_acc7", 0, 32'(dut_data[0]), 7);
        chk("clr_accval", 0, 32'(dut_acc[0]), 7);
        chk("clr_count", 0, 32'(dut_cnt[0]), 3);
        tick();

        // Backpressure
        out_ready = 1'b0;
        op(2'b00, 8'd10, 8'd20);
        tick();
        sample();
        chk("bp_valid", 0, 32'(dut_valid[0]), 1);
        chk("bp_data", 0, 32'(dut_data[0]), 30);
        chk("bp_in_ready", 0, 32'(dut_ready[0]), 0);
        op(2'b00, 8'd1, 8'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            sample();
            chk("bp_hold_data", 0, 32'(dut_data[0]), 30);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 0, 32'(dut_ready[0]), 1);
        tick();
        in_valid = 1'b0;
        sample();
        chk("bp_next_data", 0, 32'(dut_data[0]), 2);
        chk("bp_next_valid", 0, 32'(dut_valid[0]), 1);
        tick();

        // Asynchronous reset with a pending result
        op(2'b11, 8'd0, 8'd0);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        op(2'b10, 8'h42, 8'h00);
        tick();
        in_valid = 1'b0;
        sample();
        chk("ar_pre_acc", 0, 32'(dut_acc[0]), 32'h42);
        chk("ar_pre_valid", 0, 32'(dut_valid[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", 0, 32'(dut_valid[0]), 0);
        chk("ar_acc", 0, 32'(dut_acc[0]), 0);
        chk("ar_count", 0, 32'(dut_cnt[0]), 0);
        chk("ar_data", 0, 32'(dut_data[0]), 0);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Streaming
        verbose = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op(2'b00, 8'(i % 256), 8'((i * 7) % 256));
            tick();
        end
        in_valid = 1'b0;
        sample();
        chk("stream_count", 0, 32'(dut_cnt[0]), 300);

        // op_count wrap
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            op(2'b11, 8'd0, 8'd0);
            tick();
        end
        in_valid = 1'b0;
        sample();
        chk("wrap_preload", 0, 32'(dut_cnt[0]), 65535);
        op(2'b00, 8'd1, 8'd2);
        tick();
        in_valid = 1'b0;
        sample();
        chk("wrap_count", 0, 32'(dut_cnt[0]), 0);
        chk("wrap_data", 0, 32'(dut_data[0]), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_accum_unit.md
Name: add_accum_unit

Overview:
Parametrised, registered successor to the combinational top-level adder. It performs add, subtract, accumulate or clear on two unsigned operands, with valid/ready handshakes on input and output. Overflow handling is configurable (saturate or wrap), and it keeps a running accumulator and a count of accepted operations. It sits between the TT pin wrapper (ui_in/uio_in operand sources) and uo_out.

Parameters:
WIDTH, 8, operand width in bits.
ACC_WIDTH, 16, result/accumulator width; must be >= WIDTH+1.
SATURATE, 1, 1 = clamp on overflow/underflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operation request.
in_ready  output  1  block can accept an operation this cycle.
in_a  input  WIDTH  operand A, unsigned.
in_b  input  WIDTH  operand B, unsigned.
in_mode  input  2  00 add, 01 sub, 10 accumulate, 11 clear.
out_valid  output  1  result held on out_data.
out_ready  input  1  downstream accepts result.
out_data  output  ACC_WIDTH  result.
out_ovf  output  1  overflow/underflow flag paired with out_data.
acc_value  output  ACC_WIDTH  live accumulator register.
op_count  output  16  number of accepted operations, wraps at 2^16.

Behaviour:
- Reset, asynchronous, while rst=1: out_valid=0, out_data=0, out_ovf=0, acc_value=0, op_count=0. A pending unconsumed result is discarded.
- Accept condition: in_valid && in_ready, sampled at rising clk.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready only; there is no path from in_valid.
- Latency 1: an op accepted at edge N drives out_valid=1 and out_data/out_ovf after edge N.
- Throughput: 1 op/cycle when out_ready is held high.
- Output hold: while out_valid && !out_ready, out_data and out_ovf stay stable and no new op is accepted.
- out_valid clears at an edge where out_ready=1 and no new op is accepted.
- Operands are zero-extended to ACC_WIDTH+1 for all arithmetic.
- add: r = a+b. Overflow cannot occur when ACC_WIDTH >= WIDTH+1, so ovf=0. acc is unchanged.
- sub: r = a-b. If b>a, ovf=1 and the result is 0 when SATURATE=1, or (a-b) mod 2^ACC_WIDTH when SATURATE=0. acc is unchanged.
- accumulate: r = acc+a. If the sum > 2^ACC_WIDTH-1, ovf=1 and the result is all-ones when SATURATE=1, or the sum mod 2^ACC_WIDTH when SATURATE=0. acc <= r at the same edge, so out_data equals the new acc_value.
- clear: acc <= 0, out_data=0, ovf=0. in_a and in_b are ignored.
- Back-to-back accumulates use the updated acc with no bubble.
- op_count increments on every accepted op, including clear. It wraps 0xFFFF -> 0x0000.
- in_a, in_b and in_mode are don't-care when not accepted and may change freely.
- Simultaneous accept and consume (out_valid=1, out_ready=1, in_valid=1): the old result is consumed, the new result is loaded, and out_valid stays 1.
- No internal FSM beyond the out_valid flag: state EMPTY (out_valid=0) / FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with consume.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on stall.
- Top-level hookup:
  - in_a = ui_in, in_b = uio_in.
  - in_mode and handshake signals come from uio bits per the top-level pin map.
  - uo_out = out_data[7:0].

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 and acc=0x0042 -> out_valid, acc_value and op_count all 0 immediately, without waiting for clk.
- Add/sub (defaults): add 200+100 -> out_data=300, ovf=0. Sub 3-5 with SATURATE=1 -> 0, ovf=1. Same with SATURATE=0 -> 0xFFFE, ovf=1.
- Accumulate overflow (ACC_WIDTH=9): three back-to-back accumulates of a=0xFF.
  - SATURATE=1 -> outputs 255, 510, 511, with ovf=1 on the third.
  - SATURATE=0 -> outputs 255, 510, 253, with ovf=1 on the third.
- Clear: accumulate 10, clear, accumulate 7 -> outputs 10, 0, 7. acc_value=7, op_count=3.
- Backpressure: out_ready=0, send add 10+20 -> out_valid=1, out_data=30, in_ready=0. Keep the second op (add 1+1) on the inputs for 5 cycles -> out_data stays 30. Raise out_ready -> 30 consumed, then 2 appears the next cycle.
- Streaming: out_ready=1, 300 consecutive add ops -> one result per cycle, in_ready constantly 1, op_count=300. A separate run preloads 65535 ops, then one more -> op_count wraps to 0.
